// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter feeding a registered output stage with valid/ready backpressure.
// Optional hold limit: define MUX2_ARBITER_HOLD_LIMIT_EN to force rotation after MAX_HOLD beats.
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_owner;
  logic             r_sel;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             w_load_en;
  logic             w_ack0;
  logic             w_ack1;
  logic             w_ack;
  logic             w_force;

  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("mux2_arbiter: MAX_HOLD must be at least 1");
  end

  assign w_load_en = !r_out_valid || out_ready;
  assign w_ack0    = (r_state == GRANT0) && req0 && w_load_en;
  assign w_ack1    = (r_state == GRANT1) && req1 && w_load_en;
  assign w_ack     = w_ack0 || w_ack1;

`ifdef MUX2_ARBITER_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  logic [CW-1:0] r_hold_cnt;
  logic          w_limit;

  // The limit is reached either already (saturated) or by the beat being taken now.
  assign w_limit = (r_hold_cnt == HOLD_MAX) ||
                   (w_ack && (r_hold_cnt == (HOLD_MAX - CW'(1))));
  assign w_force = w_limit && (((r_state == GRANT0) && req1) ||
                               ((r_state == GRANT1) && req0));

  // Per-grant beat counter, cleared on every grant change, saturating at MAX_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_hold_cnt <= '0;
    end else if (w_ack && (r_hold_cnt != HOLD_MAX)) begin
      r_hold_cnt <= r_hold_cnt + CW'(1);
    end else begin
      r_hold_cnt <= r_hold_cnt;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // Next-state arbitration.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_next_state = r_last_owner ? GRANT0 : GRANT1;
        end else if (req0) begin
          w_next_state = GRANT0;
        end else if (req1) begin
          w_next_state = GRANT1;
        end else begin
          w_next_state = IDLE;
        end
      end
      GRANT0: begin
        if (req0 && !w_force) begin
          w_next_state = GRANT0;
        end else if (req1) begin
          w_next_state = GRANT1;
        end else begin
          w_next_state = IDLE;
        end
      end
      GRANT1: begin
        if (req1 && !w_force) begin
          w_next_state = GRANT1;
        end else if (req0) begin
          w_next_state = GRANT0;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register; last_owner and sel follow the grant being entered, held through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
      r_sel        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == GRANT0) begin
        r_last_owner <= 1'b0;
        r_sel        <= 1'b1;
      end else if (w_next_state == GRANT1) begin
        r_last_owner <= 1'b1;
        r_sel        <= 1'b0;
      end else begin
        r_last_owner <= r_last_owner;
        r_sel        <= r_sel;
      end
    end
  end

  // Output stage: load on ack, drain when the sink accepts and nothing replaces the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_ack) begin
      r_out       <= r_sel ? I0 : I1;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out       <= r_out;
      r_out_valid <= 1'b0;
    end else begin
      r_out       <= r_out;
      r_out_valid <= r_out_valid;
    end
  end

  assign gnt0      = (r_state == GRANT0);
  assign gnt1      = (r_state == GRANT1);
  assign ack0      = w_ack0;
  assign ack1      = w_ack1;
  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule
